// File: rtl/asynch_counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : asynch_counter_pkg
// Description : Shared constants for the ripple counter block.
//               Contents:
//                 c_default_width - default number of counter stages (4)
//                 c_max_width     - largest supported number of stages (32)
// Revision    : 1.0 - initial release
// ============================================================================
package asynch_counter_pkg;

  localparam int c_default_width = 4;
  localparam int c_max_width     = 32;

endpackage : asynch_counter_pkg
`default_nettype wire

// File: rtl/asynch_counter_t_ff.sv
`default_nettype none
// ============================================================================
// Module      : t_ff
// Description : Toggle flip-flop with an asynchronous active-low clear.
//               This is one stage of the ripple counter.
//               Ports:
//                 clk - stage clock; the flop acts on the rising edge
//                 rst - asynchronous clear, active low
//                 t   - toggle enable (1 = toggle, 0 = hold)
//                 q   - stage output
// Revision    : 1.0 - initial release
// ============================================================================
module t_ff (
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  logic r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q <= 1'b0;
    end else if (t) begin
      r_q <= ~r_q;
    end
  end

  assign q = r_q;

endmodule : t_ff
`default_nettype wire

// File: rtl/asynch_counter.sv
`default_nettype none
// ============================================================================
// Module      : asynch_counter
// Description : Ripple (asynchronous) binary up-counter built from a chain of
//               toggle flops. Stage 0 runs on clk. Each later stage runs on
//               the falling edge of the stage below it. The count wraps
//               modulo 2^WIDTH. There is no load input and no carry output.
//               Ports:
//                 clk - system clock; clocks stage 0 only, rising edge
//                 rst - asynchronous clear, active low, applies to all stages
//                 T   - toggle enable shared by all stages (1 = count)
//                 q   - counter value, q[0] is the LSB
//               Parameters:
//                 WIDTH - number of stages, 1..32
// Revision    : 1.0 - initial release
// ============================================================================
module asynch_counter
  import asynch_counter_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             T,
  output logic [WIDTH-1:0] q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_stage
    logic w_stage_clk;

    if (i == 0) begin : g_first
      assign w_stage_clk = clk;
    end else begin : g_ripple
      // Inverting the lower bit turns its 1->0 transition into a rising edge,
      // so this stage toggles exactly when the stage below carries out.
      assign w_stage_clk = ~q[i-1];
    end

    // Each stage samples T at its own clock edge. If T changes while a ripple
    // is still moving up the chain, the upper bits can see the new value, so
    // T must only change while clk is low.
    t_ff u_t_ff (
      .clk (w_stage_clk),
      .rst (rst),
      .t   (T),
      .q   (q[i])
    );
  end

endmodule : asynch_counter
`default_nettype wire

// File: tb/tb_asynch_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_asynch_counter
// Description : Self-checking bench for asynch_counter. It instantiates
//               WIDTH = 4, 1 and 8 copies on one shared clock, reset and
//               enable. Stimulus comes from a vector table followed by
//               hand-written sequences for mid-count reset, divider periods
//               and the 8-bit wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_asynch_counter;

  typedef struct {
    logic       rst;
    logic       t;
    logic [3:0] exp_q;
    string      name;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       t   = 1'b0;
  logic [3:0] q4;
  logic [0:0] q1;
  logic [7:0] q8;

  int n_pass  = 0;
  int n_total = 0;

  time last_rise [4];
  time period    [4];

  // Half-period of 5 units gives a 10-unit clock with rising edges at 5, 15, ...
  always #5 clk = ~clk;

  asynch_counter #(.WIDTH(4)) u_dut4 (.clk(clk), .rst(rst), .T(t), .q(q4));
  asynch_counter #(.WIDTH(1)) u_dut1 (.clk(clk), .rst(rst), .T(t), .q(q1));
  asynch_counter #(.WIDTH(8)) u_dut8 (.clk(clk), .rst(rst), .T(t), .q(q8));

  // Record the period of each bit of the 4-bit counter, measured between
  // successive rising edges of that bit.
  for (genvar b = 0; b < 4; b++) begin : g_period_mon
    always @(posedge q4[b]) begin
      period[b]    = $time - last_rise[b];
      last_rise[b] = $time;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive inputs (the clock is low here), let one rising edge pass, and
  // return on the following falling edge when the ripple has settled.
  task automatic cycle(input logic r, input logic en);
    rst = r;
    t   = en;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];

    // Power-up reset, then idle with T = 0.
    vecs.push_back('{1'b0, 1'b0, 4'd0, "reset"});
    for (int i = 0; i < 5; i++) vecs.push_back('{1'b1, 1'b0, 4'd0, "idle_hold"});
    // Free count 1..15, then the wrap to 0 on the 16th enabled edge.
    for (int i = 1; i < 16; i++) vecs.push_back('{1'b1, 1'b1, 4'(i), "count"});
    vecs.push_back('{1'b1, 1'b1, 4'd0, "wrap"});
    // Count to 6, hold for 10 edges, then resume to 7.
    for (int i = 1; i <= 6; i++) vecs.push_back('{1'b1, 1'b1, 4'(i), "count2"});
    for (int i = 0; i < 10; i++) vecs.push_back('{1'b1, 1'b0, 4'd6, "hold"});
    vecs.push_back('{1'b1, 1'b1, 4'd7, "resume"});
    // Reset, then count to 3 ready for the mid-count reset sequence.
    vecs.push_back('{1'b0, 1'b0, 4'd0, "reset2"});
    for (int i = 1; i <= 3; i++) vecs.push_back('{1'b1, 1'b1, 4'(i), "count3"});

    // Start with clk low so the first drive sits ahead of the rising edge at 5.
    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].t);
      chk(vecs[i].name, 32'(q4), 32'(vecs[i].exp_q));
      // The 1-bit counter must follow the LSB of the 4-bit one.
      chk({vecs[i].name, "_w1"}, 32'(q1), 32'(vecs[i].exp_q[0]));
    end

    // Mid-count reset: q4 = 3. Asserting rst clears q without any clock edge.
    rst = 1'b0;
    #1;
    chk("rst_async", 32'(q4), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("rst_held", 32'(q4), 32'd0);
    cycle(1'b1, 1'b1);
    chk("rst_recount1", 32'(q4), 32'd1);
    cycle(1'b1, 1'b1);
    chk("rst_recount2", 32'(q4), 32'd2);

    // Divider: count for 64 cycles from reset, then check the bit periods.
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 64; i++) cycle(1'b1, 1'b1);
    chk("div_q4_after64", 32'(q4), 32'd0);
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("div_period_q%0d", b), 32'(period[b]), 32'(20 << b));
    end

    // 8-bit wrap: 255 enabled edges reach 255, one more wraps to 0.
    cycle(1'b0, 1'b0);
    for (int i = 0; i < 255; i++) cycle(1'b1, 1'b1);
    chk("w8_at_255", 32'(q8), 32'd255);
    chk("w4_at_255", 32'(q4), 32'd15);
    chk("w1_at_255", 32'(q1), 32'd1);
    cycle(1'b1, 1'b1);
    chk("w8_wrap", 32'(q8), 32'd0);
    chk("w1_wrap", 32'(q1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_asynch_counter
`default_nettype wire

// File: doc/asynch_counter.md
# asynch_counter

Parameterizable ripple (asynchronous) binary up-counter built from a chain of toggle flip-flops. Stage 0 is clocked by the system clock. Each later stage is clocked by the falling edge of the previous stage's output. A single toggle-enable input gates counting. It is a small standalone counting/divider block, used where a cheap clock divider or event count is needed and ripple skew between bits is acceptable.

## Interface
Parameters:
- WIDTH, default 4: number of counter stages (bits of q); legal range 1..32.

Ports:
- clk  input  1  system clock; clocks stage 0 only, rising edge.
- rst  input  1  asynchronous, active-low reset; clears every stage immediately when low.
- T  input  1  toggle enable, shared by all stages; 1 = count, 0 = hold.
- q  output  WIDTH  counter value; q[0] is the LSB.

## Operation
- Reset: while rst = 0, every stage is forced to 0 asynchronously, so q = 0. Release of rst has no effect until the next qualifying edge.
- Stage 0: on each rising clk edge with rst = 1 and T = 1, q[0] <= ~q[0]. With T = 0, it holds.
- Stage i (i ≥ 1): on each falling edge of q[i-1] with rst = 1 and T = 1, q[i] <= ~q[i-1-stage-local value], i.e. q[i] toggles its own value. With T = 0 at that edge, it holds.
- Resulting sequence with T held at 1: 0, 1, 2, …, 2^WIDTH−1, 0 (wraps modulo 2^WIDTH, no terminal flag).
- T is sampled by each stage at that stage's own clock edge.
  - Dropping T between rising clk edges freezes the count at its current value.
  - If T drops while a ripple is in flight, the value may be partial. This is accepted behaviour; T should only change while clk is low.
- Reset mid-count: asserting rst at any time forces q to 0 within propagation delay, regardless of clk or T. The count restarts from 0 at the first rising clk edge after release with T = 1.
- No synchronous load, no down-count, no carry output.

## Timing
- Stage 0 latency: q[0] updates one clk-to-q delay after the rising clk edge.
- Stage i latency: q[i] settles i additional flop delays after stage 0. The q bus is only valid after the ripple settles, at most WIDTH flop delays after the rising edge.
- In zero-delay simulation all bits settle in the same timestep, so q is sampled valid on the falling clk edge.
- Reset assertion is asynchronous. Reset deassertion is not synchronized inside the block; the system releases rst away from rising clk edges, e.g. on a falling edge.
- Frequency at q[i] = f_clk / 2^(i+1) when T = 1.

## Structure
- A shared package is unnecessary. At most, a package constant for the default WIDTH (4).
- One sub-module, t_ff. Ports: clk (edge-triggered), rst (async active-low clear), t, q.
  - asynch_counter instantiates WIDTH copies in a generate loop.
  - Instance 0 is clocked by clk.
  - Instance i is clocked by ~q[i-1], so it toggles on the 1→0 transition of the previous stage.
- Flops use the standard async-clear template: sensitivity on the clock edge plus negedge rst.

## Test plan
- Power-up reset: clk period 10 ns, T = 0, hold rst = 0 for one cycle, release on a falling edge → q = 0 and remains 0 for 5 rising edges with T = 0.
- Free count: after reset, set T = 1 → q reads 1, 2, 3, 4, 5 on consecutive falling edges. After 16 rising edges q = 0 (wrap from 15).
- Reset mid-operation: T = 1, count to q = 3 (30 ns after enable), pulse rst = 0 for one cycle → q = 0 immediately and stays 0 while rst is low. After release, q counts 1, 2, … again.
- Hold: count to q = 6, drop T to 0 while clk is low → q stays 6 for 10 edges. Raise T → q = 7 on the next rising edge.
- Divider check: T = 1 for 64 cycles → q[0] period 20 ns, q[1] 40 ns, q[2] 80 ns, q[3] 160 ns.
- Parameter: WIDTH = 1 → q toggles 0/1 each rising edge. WIDTH = 8 → q wraps 255 → 0.
